seg_scan_counter: RTL and testbench

//  Parametrised multi-digit event counter with time-multiplexed 7-segment display drive.

---
 rtl/seg_pkg.sv | 28 ++
 rtl/seg_hex7_decode.sv | 27 ++
 rtl/seg_scan_counter.sv | 134 +++++++++++++
 tb/tb_seg_scan_counter.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/seg_pkg.sv
// rtl/seg_pkg.sv - segment bit order, hex pattern table and shared types
//
// Purpose: constants shared by the 7-segment decoder and the scan counter.
//   Patterns are active-high ({dp,g,f,e,d,c,b,a}, 1 = lit); the decoder
//   applies the board polarity.
// Ports: none (package).
package seg_pkg;

  typedef logic [7:0] seg_t;

  localparam int SEG_A  = 0;
  localparam int SEG_B  = 1;
  localparam int SEG_C  = 2;
  localparam int SEG_D  = 3;
  localparam int SEG_E  = 4;
  localparam int SEG_F  = 5;
  localparam int SEG_G  = 6;
  localparam int SEG_DP = 7;

  localparam seg_t SEG_OFF = 8'h00;

  // Entry [n] is the glyph for hex digit n; listed F down to 0.
  localparam logic [15:0][7:0] SEG_TABLE = {
    8'h71, 8'h79, 8'h5E, 8'h39, 8'h7C, 8'h77, 8'h6F, 8'h7F,
    8'h07, 8'h7D, 8'h6D, 8'h66, 8'h4F, 8'h5B, 8'h06, 8'h3F
  };

endpackage

// File: rtl/seg_hex7_decode.sv
// rtl/seg_hex7_decode.sv - 4-bit digit to 7-segment pattern (combinational)
//
// Purpose: look up the glyph for one digit, optionally blank it, and apply
//   the board segment polarity.
// Ports:
//   digit_i  in  4  digit value 0..F
//   blank_i  in  1  1: drive all segments off
//   seg_o    out 8  {dp,g,f,e,d,c,b,a} in board polarity
module seg_hex7_decode
  import seg_pkg::*;
#(
  parameter int ACTIVE_LOW = 1
) (
  input  logic [3:0] digit_i,
  input  logic       blank_i,
  output logic [7:0] seg_o
);

  seg_t pat;

  always_comb begin
    pat = blank_i ? SEG_OFF : SEG_TABLE[digit_i];
    pat[SEG_DP] = 1'b0;  // decimal point is never used
    seg_o = (ACTIVE_LOW != 0) ? ~pat : pat;
  end

endmodule

// File: rtl/seg_scan_counter.sv
// rtl/seg_scan_counter.sv - multi-digit event counter with multiplexed 7-seg drive
//
// Purpose: counts flag pulses into NUM_DIGITS hex/BCD digits and scans them
//   one at a time onto a shared segment bus.
// Ports:
//   clk    in   1             rising-edge clock
//   rst    in   1             asynchronous active-high reset
//   flag   in   1             increment request (once per cycle while high)
//   clr    in   1             synchronous clear, wins over flag
//   count  out  4*NUM_DIGITS  digit values, digit 0 in [3:0]
//   wrap   out  1             pulse on rollover from all-max to zero
//   sel    out  NUM_DIGITS    digit select, one active per polarity
//   seg    out  8             {dp,g,f,e,d,c,b,a}
module seg_scan_counter
  import seg_pkg::*;
#(
  parameter int NUM_DIGITS     = 6,
  parameter int SCAN_DIV       = 50000,
  parameter int DECIMAL        = 0,
  parameter int SEG_ACTIVE_LOW = 1,
  parameter int SEL_ACTIVE_LOW = 1,
  parameter int LZ_BLANK       = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    flag,
  input  logic                    clr,
  output logic [4*NUM_DIGITS-1:0] count,
  output logic                    wrap,
  output logic [NUM_DIGITS-1:0]   sel,
  output logic [7:0]              seg
);

  localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [3:0] DIGIT_MAX = (DECIMAL != 0) ? 4'd9 : 4'hF;
  localparam logic [NUM_DIGITS-1:0] SEL_OFF =
    (SEL_ACTIVE_LOW != 0) ? {NUM_DIGITS{1'b1}} : {NUM_DIGITS{1'b0}};
  localparam seg_t SEG_DARK = (SEG_ACTIVE_LOW != 0) ? ~SEG_OFF : SEG_OFF;

  logic [4*NUM_DIGITS-1:0] count_q, count_d;
  logic                    wrap_q, wrap_d;
  logic [PW-1:0]           presc_q, presc_d;
  logic [IW-1:0]           idx_q, idx_d;
  logic [NUM_DIGITS-1:0]   sel_q, sel_d;
  seg_t                    seg_q, seg_d;

  logic                    carry;
  logic [3:0]              cur_digit;
  logic                    cur_blank;
  logic                    upper_zero;
  logic [NUM_DIGITS-1:0]   onehot;

  // Ripple-carry increment: a carry survives a digit only if that digit was at max,
  // so a carry leaving the top digit means the whole count rolled over.
  always_comb begin
    count_d = count_q;
    carry   = flag;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (carry) begin
        if (count_q[4*i +: 4] == DIGIT_MAX) begin
          count_d[4*i +: 4] = 4'd0;
        end else begin
          count_d[4*i +: 4] = count_q[4*i +: 4] + 4'd1;
          carry = 1'b0;
        end
      end
    end
    wrap_d = carry;
    if (clr) begin
      count_d = '0;
      wrap_d  = 1'b0;
    end
  end

  always_comb begin
    presc_d = presc_q + PW'(1);
    idx_d   = idx_q;
    if (presc_q == PW'(SCAN_DIV - 1)) begin
      presc_d = '0;
      idx_d   = (idx_q == IW'(NUM_DIGITS - 1)) ? '0 : idx_q + IW'(1);
    end
  end

  // Walk digits from the top down so upper_zero holds "this digit and all above are zero"
  // at the moment each digit is considered.
  always_comb begin
    cur_digit  = 4'd0;
    cur_blank  = 1'b0;
    upper_zero = 1'b1;
    onehot     = '0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      upper_zero = upper_zero && (count_q[4*i +: 4] == 4'd0);
      if (idx_q == IW'(i)) begin
        cur_digit = count_q[4*i +: 4];
        cur_blank = (LZ_BLANK != 0) && (i != 0) && upper_zero;
        onehot[i] = 1'b1;
      end
    end
    sel_d = (SEL_ACTIVE_LOW != 0) ? ~onehot : onehot;
  end

  seg_hex7_decode #(
    .ACTIVE_LOW(SEG_ACTIVE_LOW)
  ) u_decode (
    .digit_i(cur_digit),
    .blank_i(cur_blank),
    .seg_o  (seg_d)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
      wrap_q  <= 1'b0;
      presc_q <= '0;
      idx_q   <= '0;
      sel_q   <= SEL_OFF;
      seg_q   <= SEG_DARK;
    end else begin
      count_q <= count_d;
      wrap_q  <= wrap_d;
      presc_q <= presc_d;
      idx_q   <= idx_d;
      sel_q   <= sel_d;
      seg_q   <= seg_d;
    end
  end

  assign count = count_q;
  assign wrap  = wrap_q;
  assign sel   = sel_q;
  assign seg   = seg_q;

endmodule

// File: tb/tb_seg_scan_counter.sv
// tb/tb_seg_scan_counter.sv - self-checking bench for seg_scan_counter
module tb_seg_scan_counter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic flag_h = 1'b0, clr_h = 1'b0;
  logic flag_b = 1'b0, clr_b = 1'b0;
  logic flag_n = 1'b0, clr_n = 1'b0;
  logic [15:0] count_h, count_b, count_n;
  logic        wrap_h, wrap_b, wrap_n;
  logic [3:0]  sel_h, sel_b, sel_n;
  logic [7:0]  seg_h, seg_b, seg_n;

  always #5 clk = ~clk;

  seg_scan_counter #(.NUM_DIGITS(4), .SCAN_DIV(4), .DECIMAL(0), .SEG_ACTIVE_LOW(1),
                     .SEL_ACTIVE_LOW(1), .LZ_BLANK(1)) dut_hex (
    .clk(clk), .rst(rst), .flag(flag_h), .clr(clr_h),
    .count(count_h), .wrap(wrap_h), .sel(sel_h), .seg(seg_h));

  seg_scan_counter #(.NUM_DIGITS(4), .SCAN_DIV(4), .DECIMAL(1), .SEG_ACTIVE_LOW(1),
                     .SEL_ACTIVE_LOW(1), .LZ_BLANK(1)) dut_bcd (
    .clk(clk), .rst(rst), .flag(flag_b), .clr(clr_b),
    .count(count_b), .wrap(wrap_b), .sel(sel_b), .seg(seg_b));

  seg_scan_counter #(.NUM_DIGITS(4), .SCAN_DIV(4), .DECIMAL(0), .SEG_ACTIVE_LOW(1),
                     .SEL_ACTIVE_LOW(1), .LZ_BLANK(0)) dut_nlz (
    .clk(clk), .rst(rst), .flag(flag_n), .clr(clr_n),
    .count(count_n), .wrap(wrap_n), .sel(sel_n), .seg(seg_n));

  int checks = 0;
  int failures = 0;

  typedef struct {
    string       tag;
    logic [31:0] exp;
  } sb_t;
  sb_t sb[$];

  logic [15:0] m_h, m_b;
  bit ok;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic push(input string tag, input logic [31:0] exp);
    sb_t e;
    e.tag = tag;
    e.exp = exp;
    sb.push_back(e);
  endtask

  task automatic pop_check(input logic [31:0] obs);
    sb_t e;
    if (sb.size() == 0) begin
      failures++;
      $error("FAIL sb_underflow observed=%h expected=<none>", obs);
    end else begin
      e = sb.pop_front();
      check(e.tag, obs, e.exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference increment computed arithmetically, independent of any digit carry logic.
  function automatic logic [15:0] inc(input logic [15:0] c, input bit dec);
    int v;
    if (!dec) return c + 16'd1;
    v = int'(c[15:12]) * 1000 + int'(c[11:8]) * 100 + int'(c[7:4]) * 10 + int'(c[3:0]);
    v = (v + 1) % 10000;
    return {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  function automatic logic [3:0] sel_of(input int which);
    return (which == 0) ? sel_h : sel_n;
  endfunction

  function automatic logic [7:0] seg_of(input int which);
    return (which == 0) ? seg_h : seg_n;
  endfunction

  // Align to the first cycle digit 0 is driven (select moves from digit 3 to digit 0).
  task automatic sync_frame(input int which, output bit found);
    logic [3:0] prev, cur;
    found = 1'b0;
    prev  = sel_of(which);
    for (int i = 0; i < 64 && !found; i++) begin
      step();
      cur = sel_of(which);
      if (prev == 4'b0111 && cur == 4'b1110) found = 1'b1;
      prev = cur;
    end
    if (!found) begin
      failures++;
      $error("FAIL sync_timeout observed=no frame start expected=frame start within 64 cycles");
    end
  endtask

  task automatic check_frame(input int which, input string tag, input logic [7:0] s0,
                             input logic [7:0] s1, input logic [7:0] s2, input logic [7:0] s3);
    logic [3:0] sels [4];
    logic [7:0] segs [4];
    sels[0] = 4'b1110; sels[1] = 4'b1101; sels[2] = 4'b1011; sels[3] = 4'b0111;
    segs[0] = s0; segs[1] = s1; segs[2] = s2; segs[3] = s3;
    for (int d = 0; d < 4; d++) begin
      for (int c = 0; c < 4; c++) begin
        push($sformatf("%s_d%0d_c%0d", tag, d, c), {20'd0, sels[d], segs[d]});
        pop_check({20'd0, sel_of(which), seg_of(which)});
        if (!(d == 3 && c == 3)) step();
      end
    end
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("rst_count", count_h, 16'h0000);
    check("rst_wrap", wrap_h, 1'b0);
    check("rst_sel", sel_h, 4'b1111);
    check("rst_seg", seg_h, 8'hFF);

    rst = 1'b0;
    step();
    check("first_sel", sel_h, 4'b1110);

    // 16 hex pulses and 10 BCD pulses both land on 0x0010
    m_h = 16'h0;
    m_b = 16'h0;
    for (int i = 0; i < 16; i++) begin
      flag_h = 1'b1;
      flag_b = (i < 10);
      m_h = inc(m_h, 1'b0);
      if (flag_b) m_b = inc(m_b, 1'b1);
      push($sformatf("cnt_hex_%0d", i), {16'd0, m_h});
      push($sformatf("cnt_bcd_%0d", i), {16'd0, m_b});
      step();
      pop_check({16'd0, count_h});
      pop_check({16'd0, count_b});
    end
    flag_h = 1'b0;
    flag_b = 1'b0;
    check("hex16", count_h, 16'h0010);
    check("bcd10", count_b, 16'h0010);

    push("hold_hex", {16'd0, m_h});
    push("hold_bcd", {16'd0, m_b});
    repeat (3) step();
    pop_check({16'd0, count_h});
    pop_check({16'd0, count_b});

    // BCD rollover 9999 -> 0000 with a one-cycle wrap
    clr_b = 1'b1;
    step();
    clr_b = 1'b0;
    check("bcd_clr", count_b, 16'h0000);
    flag_b = 1'b1;
    repeat (9999) step();
    check("bcd_9999", count_b, 16'h9999);
    check("bcd_nowrap", wrap_b, 1'b0);
    push("bcd_roll_cnt", 32'h0);
    push("bcd_roll_wrap", 32'h1);
    step();
    flag_b = 1'b0;
    pop_check({16'd0, count_b});
    pop_check({31'd0, wrap_b});
    push("bcd_wrap_drop", 32'h0);
    step();
    pop_check({31'd0, wrap_b});
    check("bcd_after", count_b, 16'h0000);

    // Hex FFFF with clr and flag together: clear wins, no wrap
    clr_h = 1'b1;
    step();
    clr_h = 1'b0;
    flag_h = 1'b1;
    repeat (65535) step();
    check("hex_ffff", count_h, 16'hFFFF);
    clr_h = 1'b1;
    push("clr_pri_cnt", 32'h0);
    push("clr_pri_wrap", 32'h0);
    step();
    clr_h = 1'b0;
    flag_h = 1'b0;
    pop_check({16'd0, count_h});
    pop_check({31'd0, wrap_h});
    step();
    check("clr_pri_wrap2", wrap_h, 1'b0);

    // Display 0x0042 with leading-zero blanking
    flag_h = 1'b1;
    repeat (66) step();
    flag_h = 1'b0;
    check("hex_42", count_h, 16'h0042);
    sync_frame(0, ok);
    if (ok) check_frame(0, "scan42", 8'hA4, 8'h99, 8'hFF, 8'hFF);

    // Zero count without blanking shows '0' on every digit
    sync_frame(1, ok);
    if (ok) check_frame(1, "scan_nlz", 8'hC0, 8'hC0, 8'hC0, 8'hC0);

    // Asynchronous reset mid-scan, between clock edges
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check("arst_count", count_h, 16'h0000);
    check("arst_wrap", wrap_h, 1'b0);
    check("arst_sel", sel_h, 4'b1111);
    check("arst_seg", seg_h, 8'hFF);
    check("arst_sel_nlz", sel_n, 4'b1111);
    check("arst_seg_nlz", seg_n, 8'hFF);
    check("arst_cnt_nlz", count_n, 16'h0000);
    check("arst_wrap_nlz", wrap_n, 1'b0);
    check("arst_sel_bcd", sel_b, 4'b1111);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
